axis_traffic_checker: RTL and testbench
=======================================

# axis_traffic_checker

Receive-side traffic checker for the AXI-Stream mesh NoC test harness. One instance sits on each router's output port, consumes every delivered packet, and maintains per-source and total receive counts for comparison against generator send counts. It validates destination, source ID, framing, per-source ordering and timestamp sanity, and raises a sticky error flag on any violation.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of all packet counters
- TDEST, 0, router index this checker is attached to (expected tdest)
- TDATA_WIDTH, 64, stream data width (must be even)
- TDEST_WIDTH, 2, tdest width
- TID_WIDTH, 2, tid (source index) width
- NUM_ROUTERS, 4, number of sources; size of recv_packets array

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- ticks  in  TDATA_WIDTH/2  free-running global timestamp
- recv_packets  out  COUNT_WIDTH x NUM_ROUTERS  packets accepted per source (index = tid)
- total_recv_packets  out  COUNT_WIDTH  all packets accepted
- error  out  1  sticky violation flag
- axis_in_tvalid  in  1  beat valid
- axis_in_tready  out  1  beat ready
- axis_in_tdata  in  TDATA_WIDTH  payload
- axis_in_tlast  in  1  end of packet
- axis_in_tid  in  TID_WIDTH  source router index
- axis_in_tdest  in  TDEST_WIDTH  destination router index

## Operation
- Packet format: single beat. tdata[TDATA_WIDTH-1:TDATA_WIDTH/2] = send timestamp (ticks value at generation); tdata[TDATA_WIDTH/2-1:0] = sequence number of this packet among packets from source tid to this destination, starting at 0.
- Beat accepted when tvalid && tready. tready = 1 whenever not in reset (checker never backpressures).
- On each accepted beat, error is set if any of:
  - tdest != TDEST
  - tid >= NUM_ROUTERS
  - tlast == 0
  - sequence field != recv_packets[tid] (zero-extended/truncated to TDATA_WIDTH/2)
  - timestamp field > ticks (packet from the future)
- On accepted beat: total_recv_packets += 1; if tid < NUM_ROUTERS, recv_packets[tid] += 1 (even if other checks fail, so one error does not cascade into sequence mismatches).
- Counters wrap modulo 2^COUNT_WIDTH; sequence comparison uses low TDATA_WIDTH/2 bits of counter.
- error is sticky: once 1, stays 1 until reset.
- No beats are dropped; data contents are not stored.

## Timing
- Reset (async assert, sync-safe release): all recv_packets = 0, total_recv_packets = 0, error = 0, tready = 0.
- First cycle after rst deasserts: tready = 1.
- Counters and error update at the rising clk edge that accepts the beat; visible next cycle (1-cycle latency).
- Checks use recv_packets value before the increment of the same edge.
- Back-to-back beats every cycle from same tid: each compared against previous-cycle-updated count; full throughput, no bubbles.
- Reset mid-operation: all state cleared immediately, in-flight beat discarded, tready low while rst high.
- tvalid with tready low (reset) has no effect.

## Test plan
- Reset: assert rst with tvalid high -> tready = 0, all counters 0, error 0; release -> tready = 1 next cycle.
- In-order traffic: TDEST=2, send 3 beats from tid 1 (seq 0,1,2) and 2 from tid 3 (seq 0,1), timestamps <= ticks, tlast=1 -> recv_packets = {0,3,0,2}, total = 5, error = 0.
- Wrong destination: one beat with tdest=1 to TDEST=2 checker -> error = 1 next cycle, total = 1; error stays 1 after further valid beats.
- Sequence gap: tid 0 beats with seq 0 then 2 -> error = 1 after second beat; recv_packets[0] = 2.
- Future timestamp / tlast=0: beat with timestamp = ticks+5 -> error = 1; separately after reset, beat with tlast=0 -> error = 1.
- Mid-run reset: after 10 accepted beats assert rst for 2 cycles -> counters 0, error 0; sequence restarts at 0 without error.

Source files
------------

// File: rtl/axis_traffic_checker_if.sv
// AXI-Stream beat bundle between a router output port and its checker.
// Ports: tvalid/tdata/tlast/tid/tdest from master, tready from slave.
interface axis_traffic_checker_if #(
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tid,
        output tdest,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tid,
        input  tdest,
        output tready
    );
endinterface

// File: rtl/axis_traffic_checker.sv
// Receive-side NoC traffic checker: counts packets per source and in
// total, and flags bad dest/tid/framing/ordering/timestamps (sticky).
// Ports: clk, rst (async, active-high), ticks (global timestamp),
// recv_packets[tid], total_recv_packets, error, axis_in (slave stream).
module axis_traffic_checker #(
    parameter int COUNT_WIDTH = 32,
    parameter int TDEST       = 0,
    parameter int TDATA_WIDTH = 64,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2,
    parameter int NUM_ROUTERS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TDATA_WIDTH/2-1:0] ticks,
    output logic [NUM_ROUTERS-1:0][COUNT_WIDTH-1:0] recv_packets,
    output logic [COUNT_WIDTH-1:0] total_recv_packets,
    output logic                   error,
    axis_traffic_checker_if.slave  axis_in
);
    localparam int HALF = TDATA_WIDTH / 2;

    logic                       tready_q;
    logic                       accept;
    logic [HALF-1:0]            seq;
    logic [HALF-1:0]            stamp;
    logic                       tid_ok;
    logic [COUNT_WIDTH-1:0]     cur_cnt;
    logic [HALF+COUNT_WIDTH-1:0] cnt_ext;
    logic [HALF-1:0]            exp_seq;
    logic                       dest_bad;
    logic                       seq_bad;
    logic                       time_bad;
    logic                       violation;

    assign axis_in.tready = tready_q;
    assign accept = axis_in.tvalid && tready_q;

    assign seq   = axis_in.tdata[HALF-1:0];
    assign stamp = axis_in.tdata[TDATA_WIDTH-1:HALF];

    // Select the count for this source without indexing past the
    // array when tid can encode more values than there are routers.
    always_comb begin
        tid_ok  = 1'b0;
        cur_cnt = '0;
        for (int i = 0; i < NUM_ROUTERS; i++) begin
            if (int'(axis_in.tid) == i) begin
                tid_ok  = 1'b1;
                cur_cnt = recv_packets[i];
            end
        end
    end

    // Widen then truncate so the sequence field matches the counter's
    // low bits whichever of the two is wider.
    assign cnt_ext = {{HALF{1'b0}}, cur_cnt};
    assign exp_seq = cnt_ext[HALF-1:0];

    assign dest_bad  = axis_in.tdest != TDEST_WIDTH'(TDEST);
    assign seq_bad   = tid_ok && (seq != exp_seq);
    assign time_bad  = stamp > ticks;
    assign violation = dest_bad || !tid_ok || !axis_in.tlast ||
                       seq_bad || time_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_recv_packets <= '0;
        end else if (accept) begin
            total_recv_packets <= total_recv_packets +
                                  COUNT_WIDTH'(1);
        end
    end

    // A source's count advances even on a failed beat so one bad
    // packet does not turn every later one into a sequence error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            recv_packets <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_ROUTERS; i++) begin
                if (int'(axis_in.tid) == i) begin
                    recv_packets[i] <= recv_packets[i] +
                                       COUNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error <= 1'b0;
        end else if (accept && violation) begin
            error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_traffic_checker.sv
// Directed scoreboard bench for axis_traffic_checker (TDEST = 2).
// Ports: none; drives the checker through its stream interface.
module tb_axis_traffic_checker;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      ticks = '0;
    logic [3:0][31:0] recv_packets;
    logic [31:0]      total;
    logic             error;

    axis_traffic_checker_if #(
        .TDATA_WIDTH(64),
        .TDEST_WIDTH(2),
        .TID_WIDTH(2)
    ) bus ();

    axis_traffic_checker #(
        .COUNT_WIDTH(32),
        .TDEST(2),
        .TDATA_WIDTH(64),
        .TDEST_WIDTH(2),
        .TID_WIDTH(2),
        .NUM_ROUTERS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ticks(ticks),
        .recv_packets(recv_packets),
        .total_recv_packets(total),
        .error(error),
        .axis_in(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ticks <= ticks + 32'd1;

    typedef struct packed {
        logic [3:0][31:0] cnt;
        logic [31:0]      tot;
        logic             err;
    } exp_t;

    exp_t             sb[$];
    logic [3:0][31:0] m_cnt;
    logic [31:0]      m_tot;
    logic             m_err;
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_cnt = '0;
        m_tot = '0;
        m_err = 1'b0;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_cnt"}, recv_packets, e.cnt);
            chk({tag, "_tot"}, 128'(total), 128'(e.tot));
            chk({tag, "_err"}, 128'(error), 128'(e.err));
        end
    endtask

    // One beat per call; consecutive calls keep tvalid high so the
    // beats arrive on back-to-back cycles.
    task automatic send(input string tag,
                        input int tid,
                        input int dest,
                        input logic [31:0] seq,
                        input int ts_off,
                        input logic last);
        exp_t        e;
        logic [31:0] ts;
        logic        bad;
        @(negedge clk);
        ts = ticks + 32'(ts_off);
        bus.tvalid = 1'b1;
        bus.tid    = 2'(tid);
        bus.tdest  = 2'(dest);
        bus.tlast  = last;
        bus.tdata  = {ts, seq};
        bad = (dest != 2) || !last ||
              (seq != m_cnt[tid]) || (ts > ticks);
        m_cnt[tid] = m_cnt[tid] + 32'd1;
        m_tot      = m_tot + 32'd1;
        m_err      = m_err | bad;
        e.cnt = m_cnt;
        e.tot = m_tot;
        e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.tvalid = 1'b0;
    endtask

    // Reset with tvalid held high: the pending beat must be dropped.
    task automatic do_reset(input string tag, input int n);
        @(negedge clk);
        bus.tvalid = 1'b1;
        bus.tid    = 2'd0;
        bus.tdest  = 2'd2;
        bus.tlast  = 1'b1;
        bus.tdata  = '0;
        rst = 1'b1;
        model_clear();
        #1;
        chk({tag, "_rdy0"}, 128'(bus.tready), 128'(0));
        chk({tag, "_cnt0"}, recv_packets, 128'(0));
        chk({tag, "_tot0"}, 128'(total), 128'(0));
        chk({tag, "_err0"}, 128'(error), 128'(0));
        repeat (n) @(negedge clk);
        chk({tag, "_hold"}, 128'(total), 128'(0));
        rst = 1'b0;
        bus.tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_rdy1"}, 128'(bus.tready), 128'(1));
        chk({tag, "_tot1"}, 128'(total), 128'(0));
    endtask

    initial begin
        bus.tvalid = 1'b0;
        bus.tid    = '0;
        bus.tdest  = '0;
        bus.tlast  = 1'b0;
        bus.tdata  = '0;
        model_clear();

        do_reset("reset", 3);

        send("ord_a", 1, 2, 32'd0, 0, 1'b1);
        send("ord_b", 1, 2, 32'd1, -1, 1'b1);
        send("ord_c", 3, 2, 32'd0, 0, 1'b1);
        send("ord_d", 1, 2, 32'd2, -2, 1'b1);
        send("ord_e", 3, 2, 32'd1, 0, 1'b1);
        idle();
        @(posedge clk);
        #1;
        chk("ord_vec", recv_packets,
            {32'd2, 32'd0, 32'd3, 32'd0});
        chk("ord_total", 128'(total), 128'(5));
        chk("ord_error", 128'(error), 128'(0));

        do_reset("rst_dest", 2);
        send("bad_dest", 0, 1, 32'd0, 0, 1'b1);
        chk("dest_total", 128'(total), 128'(1));
        send("sticky_a", 0, 2, 32'd1, 0, 1'b1);
        send("sticky_b", 2, 2, 32'd0, 0, 1'b1);
        idle();

        do_reset("rst_seq", 2);
        send("seq_0", 0, 2, 32'd0, 0, 1'b1);
        send("seq_gap", 0, 2, 32'd2, 0, 1'b1);
        chk("gap_cnt0", 128'(recv_packets[0]), 128'(2));
        chk("gap_err", 128'(error), 128'(1));
        idle();

        do_reset("rst_ts", 2);
        send("ts_eq", 2, 2, 32'd0, 0, 1'b1);
        send("ts_future", 2, 2, 32'd1, 5, 1'b1);
        idle();

        do_reset("rst_last", 2);
        send("no_last", 3, 2, 32'd0, 0, 1'b0);
        idle();

        do_reset("rst_mid", 2);
        for (int i = 0; i < 10; i++) begin
            send("run", i % 4, 2, 32'(i / 4), 0, 1'b1);
        end
        chk("run_total", 128'(total), 128'(10));
        do_reset("mid", 2);
        send("restart", 0, 2, 32'd0, 0, 1'b1);
        chk("restart_err", 128'(error), 128'(0));
        idle();

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_left observed=%0d expected=0",
                   sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=done");
        $fatal(1, "timeout");
    end
endmodule
